// File: rtl/cgra_cfg_pkg.sv
// cgra_cfg_pkg: header field layout, frame limits and loader state encoding
package cgra_cfg_pkg;
  localparam int HDR_SLOT_LSB = 0;
  localparam int HDR_SLOT_W = 4;
  localparam int HDR_PE_LSB = 4;
  localparam int HDR_PE_W = 4;
  localparam int HDR_CNT_LSB = 8;
  localparam int HDR_CNT_W = 5;
  localparam int MAX_FRAMES = 16;
  typedef enum logic [1:0] {IDLE, LO, HI, DROP} cfg_ld_state_e;
  function automatic logic hdr_cnt_ok(input logic [HDR_CNT_W-1:0] cnt);
    return (cnt != '0) && (cnt <= HDR_CNT_W'(MAX_FRAMES));
  endfunction
endpackage

// File: rtl/cgra_cfg_pe_decode.sv
// cgra_cfg_pe_decode: PE id to one-hot write enable, all-zero when not valid
module cgra_cfg_pe_decode #(
  parameter int NUM_PE = 16,
  parameter int PE_ID_WIDTH = 4
) (
  input  logic [PE_ID_WIDTH-1:0] i_pe_id,
  input  logic                   i_valid,
  output logic [NUM_PE-1:0]      o_onehot
);
  always_comb o_onehot = i_valid ? NUM_PE'(1) << i_pe_id : '0;
endmodule

// File: rtl/cgra_config_loader.sv
// cgra_config_loader: parses header+body word packets and writes 64-bit frames
// into the per-PE config memories through a registered one-hot write port
module cgra_config_loader
  import cgra_cfg_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int PE_ID_WIDTH = 4,
  parameter int DEPTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  output logic [NUM_PE-1:0]     cfg_wr_en,
  output logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  output logic [DATA_WIDTH-1:0] cfg_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           frames_written
);
  localparam int unsigned SLOT_MASK = DEPTH - 1;
  cfg_ld_state_e r_state;
  logic [ADDR_WIDTH-1:0] r_slot;
  logic [PE_ID_WIDTH-1:0] r_pe;
  logic [HDR_CNT_W-1:0] r_cnt;
  logic [HDR_CNT_W-1:0] r_idx;
  logic [31:0] r_lo;
  logic [NUM_PE-1:0] r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic r_done;
  logic r_err;
  logic [15:0] r_fw;
  logic w_acc;
  logic w_final;
  logic w_wr;
  logic [HDR_CNT_W-1:0] w_cnt;
  logic [NUM_PE-1:0] w_onehot;
  assign w_acc = in_valid && load_en;
  assign w_final = r_idx == r_cnt - HDR_CNT_W'(1);
  // a non-final HI carrying in_last is an early end: its frame is discarded
  assign w_wr = w_acc && (r_state == HI) && (w_final || !in_last);
  assign w_cnt = in_data[HDR_CNT_LSB +: HDR_CNT_W];
  assign in_ready = load_en;
  assign busy = r_state != IDLE;
  assign cfg_wr_en = r_wr_en;
  assign cfg_wr_addr = r_wr_addr;
  assign cfg_wr_data = r_wr_data;
  assign done = r_done;
  assign err = r_err;
  assign frames_written = r_fw;
  cgra_cfg_pe_decode #(
    .NUM_PE(NUM_PE),
    .PE_ID_WIDTH(PE_ID_WIDTH)
  ) u_dec (
    .i_pe_id(r_pe),
    .i_valid(w_wr),
    .o_onehot(w_onehot)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_slot <= '0;
      r_pe <= '0;
      r_cnt <= '0;
      r_idx <= '0;
      r_lo <= '0;
      r_wr_en <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_fw <= '0;
    end else begin
      r_wr_en <= w_onehot;
      r_done <= w_wr && w_final;
      if (w_wr) begin
        r_wr_addr <= (r_slot + r_idx[ADDR_WIDTH-1:0]) & SLOT_MASK[ADDR_WIDTH-1:0];
        r_wr_data <= {in_data, r_lo};
        if (r_fw != 16'hFFFF) r_fw <= r_fw + 16'd1;
      end
      if (w_acc) begin
        case (r_state)
          IDLE: begin
            r_slot <= in_data[HDR_SLOT_LSB +: ADDR_WIDTH];
            r_pe <= in_data[HDR_PE_LSB +: PE_ID_WIDTH];
            r_cnt <= w_cnt;
            r_idx <= '0;
            r_err <= r_err | in_last | !hdr_cnt_ok(w_cnt);
            r_state <= in_last ? IDLE : hdr_cnt_ok(w_cnt) ? LO : DROP;
          end
          LO: begin
            r_lo <= in_data;
            r_err <= r_err | in_last;
            r_state <= in_last ? IDLE : HI;
          end
          HI: begin
            r_idx <= r_idx + HDR_CNT_W'(1);
            r_err <= r_err | (in_last != w_final);
            r_state <= (in_last || w_final) ? IDLE : LO;
          end
          DROP: r_state <= in_last ? IDLE : DROP;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
